// File: rtl/noc_packet_sink_checker_if.sv
// Router local-port sender bundle as seen by a receiving sink.
//   receive_valid     : flit valid from the router
//   receive_ready     : sink can accept a flit this cycle
//   receive_flit      : flit data
//   receive_is_header : flit is a packet header
//   receive_is_tail   : flit is the last flit of a packet
// master = router side (drives flits), slave = sink side (drives ready).
interface noc_packet_sink_checker_if #(
    parameter int unsigned FLIT_W = 32
);
    logic              receive_valid;
    logic              receive_ready;
    logic [FLIT_W-1:0] receive_flit;
    logic              receive_is_header;
    logic              receive_is_tail;

    modport master (
        output receive_valid,
        output receive_flit,
        output receive_is_header,
        output receive_is_tail,
        input  receive_ready
    );

    modport slave (
        input  receive_valid,
        input  receive_flit,
        input  receive_is_header,
        input  receive_is_tail,
        output receive_ready
    );
endinterface

// File: rtl/noc_packet_sink_checker.sv
// Receive-end traffic checker for the mesh NoC test fabric.
// Consumes packets from a router local port, checks framing, destination,
// sequence and payload, and reports saturating counters and sticky errors.
//   noc_clk, noc_rst_n : fabric clock, asynchronous active-low reset
//   rx                 : router sender bundle (slave side; drives ready)
//   pkt_count          : packets completed (tail accepted)
//   good_pkt_count     : packets completed with no error
//   err_count          : erroneous flits accepted
//   err_flags          : sticky {data,len,seq,dest,frame}
//   last_src           : src field of the most recent accepted header
//   busy               : mid-packet
module noc_packet_sink_checker #(
    parameter int unsigned FLIT_W       = 32,
    parameter int unsigned X_ID         = 0,
    parameter int unsigned Y_ID         = 0,
    parameter int unsigned STALL_PERIOD = 0
) (
    input  logic                            noc_clk,
    input  logic                            noc_rst_n,
    noc_packet_sink_checker_if.slave        rx,
    output logic [15:0]                     pkt_count,
    output logic [15:0]                     good_pkt_count,
    output logic [7:0]                      err_count,
    output logic [4:0]                      err_flags,
    output logic [7:0]                      last_src,
    output logic                            busy
);
    localparam int unsigned ERR_FRAME = 0;
    localparam int unsigned ERR_DEST  = 1;
    localparam int unsigned ERR_SEQ   = 2;
    localparam int unsigned ERR_LEN   = 3;
    localparam int unsigned ERR_DATA  = 4;
    localparam int unsigned CNT_W     = (STALL_PERIOD >= 2) ? $clog2(STALL_PERIOD) : 1;

    typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

    typedef struct packed {
        logic [7:0] len;
        logic [7:0] seq;
        logic [7:0] src;
        logic [3:0] dest_y;
        logic [3:0] dest_x;
    } hdr_t;

    state_t     state_q, state_d;
    logic [7:0] exp_seq_q, exp_seq_d;
    logic [7:0] cur_seq_q, cur_seq_d;
    logic [7:0] cur_len_q, cur_len_d;
    logic [7:0] idx_q, idx_d;
    logic       pkt_err_q, pkt_err_d;
    logic       len_flag_q, len_flag_d;
    logic [7:0] last_src_d;
    logic [4:0] errs;
    logic       done;
    logic       ready_q;
    logic       xfer;
    logic [31:0] flit;
    hdr_t       hdr;
    logic [7:0] last_idx;

    assign rx.receive_ready = ready_q;
    assign xfer     = rx.receive_valid & ready_q;
    assign flit     = rx.receive_flit[31:0];
    assign hdr      = flit;
    assign last_idx = cur_len_q - 8'd1;

    // Periodic backpressure: ready is registered so valid never reaches it combinationally.
    if (STALL_PERIOD >= 2) begin : g_stall
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STALL_PERIOD - 1)) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge noc_clk or negedge noc_rst_n) begin
            if (!noc_rst_n) begin
                cnt_q   <= '0;
                ready_q <= 1'b1;
            end else begin
                cnt_q   <= cnt_d;
                ready_q <= (cnt_d != CNT_W'(STALL_PERIOD - 1));
            end
        end
    end else begin : g_no_stall
        assign ready_q = 1'b1;
    end

    // Next-state and per-flit checks.
    always_comb begin
        state_d    = state_q;
        exp_seq_d  = exp_seq_q;
        cur_seq_d  = cur_seq_q;
        cur_len_d  = cur_len_q;
        idx_d      = idx_q;
        pkt_err_d  = pkt_err_q;
        len_flag_d = len_flag_q;
        last_src_d = last_src;
        errs       = '0;
        done       = 1'b0;

        if (xfer) begin
            if (rx.receive_is_header) begin
                // A header mid-packet abandons the open packet, then starts a new one.
                if (state_q == BODY) begin
                    errs[ERR_FRAME] = 1'b1;
                end
                if (hdr.dest_x != 4'(X_ID) || hdr.dest_y != 4'(Y_ID)) begin
                    errs[ERR_DEST] = 1'b1;
                end
                if (hdr.seq != exp_seq_q) begin
                    errs[ERR_SEQ] = 1'b1;
                end
                exp_seq_d  = hdr.seq + 8'd1;
                last_src_d = hdr.src;
                cur_seq_d  = hdr.seq;
                cur_len_d  = hdr.len;
                idx_d      = '0;
                len_flag_d = 1'b0;
                if (rx.receive_is_tail) begin
                    if (hdr.len != 8'd0) begin
                        errs[ERR_LEN] = 1'b1;
                    end
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (hdr.len == 8'd0) begin
                        errs[ERR_LEN] = 1'b1;
                    end
                    state_d = BODY;
                end
                // Abandonment frame error belongs to the old packet, not the new one.
                pkt_err_d = |errs[4:1];
            end else if (state_q == IDLE) begin
                errs[ERR_FRAME] = 1'b1;
            end else begin
                if (idx_q < cur_len_q && flit[15:0] != {cur_seq_q, idx_q}) begin
                    errs[ERR_DATA] = 1'b1;
                end
                if (rx.receive_is_tail && idx_q != last_idx) begin
                    errs[ERR_LEN] = 1'b1;
                end
                if (!rx.receive_is_tail && idx_q == last_idx && !len_flag_q) begin
                    errs[ERR_LEN] = 1'b1;
                    len_flag_d    = 1'b1;
                end
                pkt_err_d = pkt_err_q | (|errs);
                if (rx.receive_is_tail) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (idx_q != 8'hFF) begin
                    idx_d = idx_q + 8'd1;
                end
            end
        end
    end

    // State, datapath and saturating counters.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q        <= IDLE;
            exp_seq_q      <= '0;
            cur_seq_q      <= '0;
            cur_len_q      <= '0;
            idx_q          <= '0;
            pkt_err_q      <= 1'b0;
            len_flag_q     <= 1'b0;
            pkt_count      <= '0;
            good_pkt_count <= '0;
            err_count      <= '0;
            err_flags      <= '0;
            last_src       <= '0;
            busy           <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_seq_q  <= exp_seq_d;
            cur_seq_q  <= cur_seq_d;
            cur_len_q  <= cur_len_d;
            idx_q      <= idx_d;
            pkt_err_q  <= pkt_err_d;
            len_flag_q <= len_flag_d;
            last_src   <= last_src_d;
            busy       <= (state_d == BODY);
            err_flags  <= err_flags | errs;
            if (errs != '0 && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            if (done && pkt_count != 16'hFFFF) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (done && !pkt_err_d && good_pkt_count != 16'hFFFF) begin
                good_pkt_count <= good_pkt_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_noc_packet_sink_checker.sv
// Scoreboard bench for noc_packet_sink_checker (node (1,1), ready stalls 1 in 4).
module tb_noc_packet_sink_checker;
    localparam int unsigned FLIT_W = 32;

    logic        noc_clk = 1'b0;
    logic        noc_rst_n;
    logic [15:0] pkt_count;
    logic [15:0] good_pkt_count;
    logic [7:0]  err_count;
    logic [4:0]  err_flags;
    logic [7:0]  last_src;
    logic        busy;

    always #5 noc_clk = ~noc_clk;

    noc_packet_sink_checker_if #(.FLIT_W(FLIT_W)) rx ();

    noc_packet_sink_checker #(
        .FLIT_W(FLIT_W), .X_ID(1), .Y_ID(1), .STALL_PERIOD(4)
    ) u_dut (
        .noc_clk        (noc_clk),
        .noc_rst_n      (noc_rst_n),
        .rx             (rx),
        .pkt_count      (pkt_count),
        .good_pkt_count (good_pkt_count),
        .err_count      (err_count),
        .err_flags      (err_flags),
        .last_src       (last_src),
        .busy           (busy)
    );

    typedef struct {
        int pkt;
        int good;
        int errc;
        int flags;
        int src;
        int busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_xfer = 0;

    // Reference model state, kept as plain integers.
    int m_busy, m_exp_seq, m_seq, m_len, m_idx, m_pkt_err, m_len_flagged;
    int m_pkt, m_good, m_errc, m_flags, m_src;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_exp_seq = 0; m_seq = 0; m_len = 0; m_idx = 0;
        m_pkt_err = 0; m_len_flagged = 0;
        m_pkt = 0; m_good = 0; m_errc = 0; m_flags = 0; m_src = 0;
    endtask

    // Error bits: 1 frame, 2 dest, 4 seq, 8 len, 16 data.
    task automatic model_flit(input logic [31:0] f, input bit h, input bit t);
        int  e;
        bit  done;
        int  last;
        e = 0;
        done = 0;
        if (h) begin
            if (m_busy != 0) e |= 1;
            if (int'(f[3:0]) != 1 || int'(f[7:4]) != 1) e |= 2;
            if (int'(f[23:16]) != m_exp_seq) e |= 4;
            m_exp_seq = (int'(f[23:16]) + 1) % 256;
            m_src = int'(f[15:8]);
            m_seq = int'(f[23:16]);
            m_len = int'(f[31:24]);
            m_idx = 0;
            m_len_flagged = 0;
            if (t) begin
                if (m_len != 0) e |= 8;
                done = 1;
                m_busy = 0;
            end else begin
                if (m_len == 0) e |= 8;
                m_busy = 1;
            end
            m_pkt_err = ((e & 30) != 0) ? 1 : 0;
        end else if (m_busy == 0) begin
            e |= 1;
        end else begin
            if (m_idx < m_len && int'(f[15:0]) != m_seq * 256 + m_idx) e |= 16;
            last = (m_len + 255) % 256;
            if (t && m_idx != last) e |= 8;
            if (!t && m_idx == last && m_len_flagged == 0) begin
                e |= 8;
                m_len_flagged = 1;
            end
            if (e != 0) m_pkt_err = 1;
            if (t) begin
                done = 1;
                m_busy = 0;
            end else if (m_idx < 255) begin
                m_idx++;
            end
        end
        if (e != 0) begin
            if (m_errc < 255) m_errc++;
            m_flags |= e;
        end
        if (done) begin
            if (m_pkt < 65535) m_pkt++;
            if (m_pkt_err == 0 && m_good < 65535) m_good++;
        end
    endtask

    task automatic push_expected();
        exp_t s;
        s.pkt = m_pkt; s.good = m_good; s.errc = m_errc;
        s.flags = m_flags; s.src = m_src; s.busy = m_busy;
        exp_q.push_back(s);
    endtask

    function automatic logic [31:0] hdr(input int dx, input int dy, input int src,
                                        input int seq, input int len);
        return {8'(len), 8'(seq), 8'(src), 4'(dy), 4'(dx)};
    endfunction

    // Drive one flit from a negedge; returns at the negedge after it is accepted.
    task automatic send(input logic [31:0] f, input bit h, input bit t);
        int guard;
        guard = 0;
        rx.receive_flit      = f;
        rx.receive_is_header = h;
        rx.receive_is_tail   = t;
        rx.receive_valid     = 1'b1;
        while (!rx.receive_ready) begin
            @(negedge noc_clk);
            guard++;
            if (guard > 8) begin
                check("ready_timeout", 0, 1);
                break;
            end
        end
        model_flit(f, h, t);
        push_expected();
        @(negedge noc_clk);
        rx.receive_valid = 1'b0;
    endtask

    function automatic logic [31:0] payload(input int seq, input int i);
        logic [31:0] r;
        r = $urandom();
        return {r[31:16], 8'(seq), 8'(i)};
    endfunction

    task automatic apply_reset();
        @(negedge noc_clk);
        noc_rst_n = 1'b0;
        rx.receive_valid = 1'b0;
        repeat (2) @(negedge noc_clk);
        exp_q.delete();
        model_reset();
        noc_rst_n = 1'b1;
    endtask

    task automatic drain();
        @(negedge noc_clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: every accepted flit is compared against the next expected snapshot.
    always @(posedge noc_clk) begin
        if (noc_rst_n && rx.receive_valid && rx.receive_ready) begin
            exp_t e;
            n_xfer++;
            @(negedge noc_clk);
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pkt_count", int'(pkt_count), e.pkt);
                check("good_pkt_count", int'(good_pkt_count), e.good);
                check("err_count", int'(err_count), e.errc);
                check("err_flags", int'(err_flags), e.flags);
                check("last_src", int'(last_src), e.src);
                check("busy", int'(busy), e.busy);
            end
        end
    end

    task automatic rand_packet();
        int len, mut, seq, dx, src, tail_at, stop_at, bad_at;
        logic [31:0] d;
        len = $urandom_range(0, 4);
        mut = $urandom_range(0, 15);
        seq = m_exp_seq;
        dx  = 1;
        src = $urandom_range(0, 255);
        if (mut == 1) seq = (seq + $urandom_range(1, 255)) % 256;
        if (mut == 2) dx = 0;
        if (mut == 3) send(payload(0, 0), 1'b0, 1'b0);
        if (len == 0) begin
            send(hdr(dx, 1, src, seq, 0), 1'b1, mut != 4);
            return;
        end
        send(hdr(dx, 1, src, seq, len), 1'b1, 1'b0);
        tail_at = len - 1;
        stop_at = -1;
        bad_at  = -1;
        if (mut == 5) tail_at = $urandom_range(0, len - 1);
        if (mut == 6) begin
            tail_at = -1;
            stop_at = $urandom_range(0, len - 1);
        end
        if (mut == 7) tail_at = len + $urandom_range(0, 2);
        if (mut == 8) bad_at = $urandom_range(0, len - 1);
        for (int i = 0; i < 16; i++) begin
            d = payload(seq, i);
            if (i == bad_at) d = d ^ (32'd1 << $urandom_range(0, 15));
            send(d, 1'b0, i == tail_at);
            repeat ($urandom_range(0, 2)) @(negedge noc_clk);
            if (i == tail_at || i == stop_at) break;
        end
    endtask

    initial begin
        int seen;
        rx.receive_valid = 1'b0;
        rx.receive_flit = '0;
        rx.receive_is_header = 1'b0;
        rx.receive_is_tail = 1'b0;
        noc_rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge noc_clk);
        check("reset_pkt", int'(pkt_count), 0);
        check("reset_err_flags", int'(err_flags), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(rx.receive_ready), 1);
        noc_rst_n = 1'b1;

        // Four clean packets, len 3.
        for (int p = 0; p < 4; p++) begin
            send(hdr(1, 1, 8'h40 + p, p, 3), 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) send(payload(p, i), 1'b0, i == 2);
        end
        drain();
        check("t1_pkt", int'(pkt_count), 4);
        check("t1_good", int'(good_pkt_count), 4);
        check("t1_errc", int'(err_count), 0);
        check("t1_flags", int'(err_flags), 0);

        // Single-flit packets: len 0 clean, then len 2 with tail on header.
        apply_reset();
        send(hdr(1, 1, 3, 0, 0), 1'b1, 1'b1);
        drain();
        check("t2a_pkt", int'(pkt_count), 1);
        check("t2a_good", int'(good_pkt_count), 1);
        send(hdr(1, 1, 3, 1, 2), 1'b1, 1'b1);
        drain();
        check("t2b_pkt", int'(pkt_count), 2);
        check("t2b_good", int'(good_pkt_count), 1);
        check("t2b_flags", int'(err_flags), 5'b01000);

        // Wrong destination, then sequence jump; exp_seq resyncs to 6.
        apply_reset();
        send(hdr(0, 1, 7, 0, 0), 1'b1, 1'b1);
        send(hdr(1, 1, 7, 5, 0), 1'b1, 1'b1);
        send(hdr(1, 1, 7, 6, 0), 1'b1, 1'b1);
        drain();
        check("t3_flags", int'(err_flags), 5'b00110);
        check("t3_errc", int'(err_count), 2);
        check("t3_pkt", int'(pkt_count), 3);

        // New header before tail abandons the first packet.
        apply_reset();
        send(hdr(1, 1, 9, 0, 2), 1'b1, 1'b0);
        send(payload(0, 0), 1'b0, 1'b0);
        send(hdr(1, 1, 9, 1, 1), 1'b1, 1'b0);
        send(payload(1, 0), 1'b0, 1'b1);
        drain();
        check("t4_pkt", int'(pkt_count), 1);
        check("t4_flags", int'(err_flags), 5'b00001);
        check("t4_errc", int'(err_count), 1);

        // Corrupted payload flit 1.
        apply_reset();
        send(hdr(1, 1, 2, 0, 2), 1'b1, 1'b0);
        send(32'h0000_0000, 1'b0, 1'b0);
        send(32'h0000_0002, 1'b0, 1'b1);
        drain();
        check("t5_flags", int'(err_flags), 5'b10000);
        check("t5_pkt", int'(pkt_count), 1);
        check("t5_good", int'(good_pkt_count), 0);
        check("t5_errc", int'(err_count), 1);

        // Valid held high 40 cycles with 1-in-4 stall: 30 transfers.
        apply_reset();
        @(negedge noc_clk);
        rx.receive_flit = 32'h1234_5678;
        rx.receive_is_header = 1'b0;
        rx.receive_is_tail = 1'b0;
        rx.receive_valid = 1'b1;
        seen = n_xfer;
        for (int c = 0; c < 40; c++) begin
            if (rx.receive_ready) begin
                model_flit(rx.receive_flit, 1'b0, 1'b0);
                push_expected();
            end
            @(negedge noc_clk);
        end
        rx.receive_valid = 1'b0;
        check("t6_transfers", n_xfer - seen, 30);
        drain();
        check("t6_errc", int'(err_count), 30);

        // Reset in mid-packet, then a clean packet.
        send(hdr(1, 1, 5, 0, 3), 1'b1, 1'b0);
        send(payload(0, 0), 1'b0, 1'b0);
        drain();
        check("t6_busy_before", int'(busy), 1);
        apply_reset();
        check("t6_rst_pkt", int'(pkt_count), 0);
        check("t6_rst_errc", int'(err_count), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_src", int'(last_src), 0);
        send(hdr(1, 1, 5, 0, 1), 1'b1, 1'b0);
        send(payload(0, 0), 1'b0, 1'b1);
        drain();
        check("t6_after_pkt", int'(pkt_count), 1);
        check("t6_after_good", int'(good_pkt_count), 1);

        // Random traffic with occasional faults.
        apply_reset();
        for (int p = 0; p < 200; p++) begin
            rand_packet();
            repeat ($urandom_range(0, 2)) @(negedge noc_clk);
        end
        drain();
        check("rand_final_pkt", int'(pkt_count), m_pkt);
        check("rand_final_good", int'(good_pkt_count), m_good);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
